// File: rtl/auto_motion_sequencer.sv
// Tick-timed maze-driving sequencer: MOVE -> WAIT -> DECIDE -> TURN -> MOVE.
// DECIDE picks a heading by the right-hand rule and flags forks and dead ends.
module auto_motion_sequencer #(
  parameter int CNT_W      = 8,
  parameter int MOVE_TICKS = 3,
  parameter int WAIT_TICKS = 1,
  parameter int TURN_TICKS = 5
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       power,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] turn_detector,
  output logic [3:0] next_turn,
  output logic       motor_en,
  output logic [2:0] next_state,
  output logic       pl_beacon_sig,
  output logic       de_beacon_sig,
  output logic [7:0] step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_WAIT   = 3'd2,
    S_DECIDE = 3'd3,
    S_TURN   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_FRONT = 4'b0001;
  localparam logic [3:0] DIR_BACK  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TICKS - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(2 * TURN_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dir_q, dir_d;
  logic [3:0]       next_turn_d;
  logic             motor_en_d, pl_d, de_d;
  logic [7:0]       step_d;

  logic             left_clr, right_clr, front_clr;
  logic [1:0]       open_cnt;
  logic [CNT_W-1:0] turn_last;

  // Detector flags are {left,right,back,front}; back never influences the choice.
  assign left_clr  = ~turn_detector[3];
  assign right_clr = ~turn_detector[2];
  assign front_clr = ~turn_detector[0];
  assign open_cnt  = 2'(left_clr) + 2'(right_clr) + 2'(front_clr);
  assign turn_last = (dir_q == DIR_BACK) ? UTURN_LAST : TURN_LAST;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_d  = step_cnt;
    pl_d    = 1'b0;
    de_d    = 1'b0;

    if (!power || stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) state_d = S_MOVE;
        end
        S_MOVE: begin
          if (tick) begin
            if (cnt_q == MOVE_LAST) state_d = S_WAIT;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (tick) begin
            if (cnt_q == WAIT_LAST) state_d = S_DECIDE;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        S_DECIDE: begin
          step_d = step_cnt + 8'd1;
          pl_d   = (open_cnt >= 2'd2);
          de_d   = (open_cnt == 2'd0);
          if (right_clr) begin
            dir_d   = DIR_RIGHT;
            state_d = S_TURN;
          end else if (front_clr) begin
            dir_d   = DIR_FRONT;
            state_d = S_MOVE;
          end else if (left_clr) begin
            dir_d   = DIR_LEFT;
            state_d = S_TURN;
          end else begin
            dir_d   = DIR_BACK;
            state_d = S_TURN;
          end
        end
        S_TURN: begin
          if (tick) begin
            if (cnt_q == turn_last) state_d = S_MOVE;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Entering any state restarts the phase count, so an entry-cycle tick is never counted.
    if (state_d != state_q) cnt_d = '0;

    motor_en_d = (state_d == S_MOVE) || (state_d == S_TURN);
    case (state_d)
      S_MOVE:  next_turn_d = DIR_FRONT;
      S_TURN:  next_turn_d = dir_d;
      default: next_turn_d = DIR_NONE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      dir_q         <= DIR_NONE;
      next_turn     <= DIR_NONE;
      motor_en      <= 1'b0;
      pl_beacon_sig <= 1'b0;
      de_beacon_sig <= 1'b0;
      step_cnt      <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      next_turn     <= next_turn_d;
      motor_en      <= motor_en_d;
      pl_beacon_sig <= pl_d;
      de_beacon_sig <= de_d;
      step_cnt      <= step_d;
    end
  end

  assign next_state = state_q;

endmodule

// File: tb/tb_auto_motion_sequencer.sv
// Randomized bench for auto_motion_sequencer: a step-level model predicts each
// MOVE/WAIT/DECIDE/TURN cycle in ticks and checks outputs at every tick.
module tb_auto_motion_sequencer;

  localparam int MOVE_TICKS = 3;
  localparam int WAIT_TICKS = 1;
  localparam int TURN_TICKS = 5;

  localparam logic [7:0] ST_IDLE   = 8'd0;
  localparam logic [7:0] ST_MOVE   = 8'd1;
  localparam logic [7:0] ST_WAIT   = 8'd2;
  localparam logic [7:0] ST_DECIDE = 8'd3;
  localparam logic [7:0] ST_TURN   = 8'd4;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       power = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] turn_detector = 4'b0000;
  logic [3:0] next_turn;
  logic       motor_en;
  logic [2:0] next_state;
  logic       pl_beacon_sig;
  logic       de_beacon_sig;
  logic [7:0] step_cnt;

  int checks = 0;
  int errors = 0;
  int decides = 0;

  auto_motion_sequencer #(
    .CNT_W(8), .MOVE_TICKS(MOVE_TICKS), .WAIT_TICKS(WAIT_TICKS), .TURN_TICKS(TURN_TICKS)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .tick(tick), .power(power), .start(start), .stop(stop),
    .turn_detector(turn_detector), .next_turn(next_turn), .motor_en(motor_en),
    .next_state(next_state), .pl_beacon_sig(pl_beacon_sig), .de_beacon_sig(de_beacon_sig),
    .step_cnt(step_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle a random number of cycles, then one tick (optionally with stop); returns on the following negedge.
  task automatic do_tick(input bit with_stop);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge sys_clk);
    tick = 1'b1;
    stop = with_stop;
    @(negedge sys_clk);
    tick = 1'b0;
    stop = 1'b0;
  endtask

  // Right-hand-rule reference: returns heading, resulting state, turn length and beacons.
  task automatic model_decide(input logic [3:0] det, output logic [3:0] dir,
                              output logic [7:0] st, output int ticks,
                              output logic pl, output logic de);
    int open;
    bit l_ok, r_ok, f_ok;
    l_ok = (det[3] == 1'b0);
    r_ok = (det[2] == 1'b0);
    f_ok = (det[0] == 1'b0);
    open = int'(l_ok) + int'(r_ok) + int'(f_ok);
    pl = (open >= 2);
    de = (open == 0);
    ticks = TURN_TICKS;
    st = ST_TURN;
    if (r_ok)      dir = 4'b0100;
    else if (f_ok) begin dir = 4'b0001; st = ST_MOVE; ticks = 0; end
    else if (l_ok) dir = 4'b1000;
    else begin dir = 4'b0010; ticks = 2 * TURN_TICKS; end
  endtask

  // One full step starting freshly in MOVE. With stop_turn, stop accompanies the 3rd TURN tick.
  task automatic run_step(input logic [3:0] det, input bit stop_turn);
    logic [3:0] dir;
    logic [7:0] st;
    logic       pl, de;
    int         ticks;
    for (int i = 0; i < MOVE_TICKS; i++) begin
      turn_detector = 4'($urandom);
      do_tick(1'b0);
      if (i < MOVE_TICKS - 1) begin
        check("move_state", 8'(next_state), ST_MOVE);
        check("move_turn", 8'(next_turn), 8'h01);
      end else begin
        check("wait_state", 8'(next_state), ST_WAIT);
        check("wait_motor", 8'(motor_en), 8'd0);
        check("wait_turn", 8'(next_turn), 8'h00);
      end
    end
    turn_detector = det;
    for (int i = 0; i < WAIT_TICKS; i++) begin
      do_tick(1'b0);
      if (i == WAIT_TICKS - 1) check("decide_state", 8'(next_state), ST_DECIDE);
    end
    @(negedge sys_clk);
    model_decide(det, dir, st, ticks, pl, de);
    decides++;
    check("post_decide_state", 8'(next_state), st);
    check("post_decide_turn", 8'(next_turn), 8'(dir));
    check("post_decide_motor", 8'(motor_en), 8'd1);
    check("pl_beacon", 8'(pl_beacon_sig), 8'(pl));
    check("de_beacon", 8'(de_beacon_sig), 8'(de));
    check("step_cnt", step_cnt, 8'(decides));
    turn_detector = 4'($urandom);
    @(negedge sys_clk);
    check("pl_beacon_end", 8'(pl_beacon_sig), 8'd0);
    check("de_beacon_end", 8'(de_beacon_sig), 8'd0);
    for (int t = 0; t < ticks; t++) begin
      turn_detector = 4'($urandom);
      if (stop_turn && t == 2) begin
        do_tick(1'b1);
        check("stop_state", 8'(next_state), ST_IDLE);
        check("stop_motor", 8'(motor_en), 8'd0);
        check("stop_turn", 8'(next_turn), 8'h00);
        check("stop_beacons", 8'({pl_beacon_sig, de_beacon_sig}), 8'd0);
        return;
      end
      do_tick(1'b0);
      if (t < ticks - 1) begin
        check("turn_state", 8'(next_state), ST_TURN);
        check("turn_dir", 8'(next_turn), 8'(dir));
        check("turn_motor", 8'(motor_en), 8'd1);
      end else begin
        check("turn_done_state", 8'(next_state), ST_MOVE);
        check("turn_done_dir", 8'(next_turn), 8'h01);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with start pulsing.
    @(negedge sys_clk);
    rst = 1'b1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0; start = 1'b0;
    check("rst_state", 8'(next_state), ST_IDLE);
    check("rst_turn", 8'(next_turn), 8'h00);
    check("rst_motor", 8'(motor_en), 8'd0);
    check("rst_pl", 8'(pl_beacon_sig), 8'd0);
    check("rst_de", 8'(de_beacon_sig), 8'd0);
    check("rst_step", step_cnt, 8'd0);

    pulse_start();
    check("start_state", 8'(next_state), ST_MOVE);
    check("start_motor", 8'(motor_en), 8'd1);
    check("start_turn", 8'(next_turn), 8'h01);
    pulse_start();
    check("start_ignored", 8'(next_state), ST_MOVE);

    run_step(4'b0000, 1'b0);
    run_step(4'b1101, 1'b0);
    run_step(4'b0101, 1'b0);
    run_step(4'b0110, 1'b0);

    repeat (24) run_step(4'($urandom), 1'b0);

    run_step(4'b0000, 1'b1);
    pulse_start();
    check("restart_state", 8'(next_state), ST_MOVE);

    @(negedge sys_clk);
    power = 1'b0;
    @(negedge sys_clk);
    check("power_state", 8'(next_state), ST_IDLE);
    check("power_motor", 8'(motor_en), 8'd0);
    check("power_turn", 8'(next_turn), 8'h00);
    power = 1'b1;
    pulse_start();
    check("power_restart", 8'(next_state), ST_MOVE);

    // Fast front-only steps until the 256th decision wraps the counter.
    while (decides < 256) begin
      logic [3:0] d;
      d = 4'($urandom);
      d[2] = 1'b1;
      d[0] = 1'b0;
      run_step(d, 1'b0);
    end
    check("step_wrap", step_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
